arcade_input_mapper: RTL and testbench
======================================

// Module: arcade_input_mapper
// PURPOSE
//  Converts PS/2 key events and HPS joystick words into registered player controls for the game core.
//  Sits between hps_io (ps2_key, joystick_0/1) and the game core's control inputs.
//  Adds a coin-pulse shaper so each coin request reaches the core as exactly one fixed-width pulse.
//  Optional autofire is available on the fire buttons.
// PARAMETERS
//  COIN_PULSE    120000   coin output high time, clk_sys cycles (10 ms at 12 MHz); >=1
//  COIN_GAP      1200000  minimum low time after a coin pulse (100 ms); >=1
//  AUTOFIRE_DIV  300000   autofire half-period, cycles (20 Hz at 12 MHz); >=1
// PORTS
//  clk_sys     in   1   system clock; sole clock domain
//  reset_n     in   1   synchronous reset, active-low
//  ps2_key     in   11  [10] toggles once per event, [9] pressed, [8] extended, [7:0] scancode
//  joystick_0  in   16  P1: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2 [7]coin
//  joystick_1  in   16  P2: same map; [5] means start2
//  autofire    in   1   autofire request; ignored unless INPUT_AUTOFIRE_EN is defined
//  p1_ctl      out  5   {fire,up,down,left,right}, player 1
//  p2_ctl      out  5   {fire,up,down,left,right}, player 2
//  start1      out  1   player 1 start
//  start2      out  1   player 2 start
//  coin        out  1   shaped coin pulse
// BEHAVIOUR
//  Reset (reset_n=0 at an edge):
//   - all outputs 0; all key latches 0; coin FSM to IDLE; counters 0.
//   - old_tgl <= ps2_key[10]; no spurious event after reset.
//  Key events:
//   - An event is ps2_key[10] != old_tgl. old_tgl updates every cycle.
//   - The matching key latch <= ps2_key[9] in the same cycle.
//  Key table (ext=don't-care for arrows and ctrl; ext=0 for all others):
//   - Arrows 75/72/6B/74 -> P1 U/D/L/R.
//   - 29 space, 14 ctrl -> P1 fire.
//   - 05 F1, 16 '1' -> start1.
//   - 06 F2, 1E '2' -> start2.
//   - 2E '5', 36 '6' -> coin request.
//   - 2D/2B/23/34 R/F/D/G -> P2 U/D/L/R.
//   - 1C A -> P2 fire.
//   - Unlisted codes are ignored.
//  Latches:
//   - Every key has its own latch. Keys sharing a function are ORed, so releasing ctrl while space is held keeps fire=1.
//  Merge, registered, 1-cycle latency from input to output:
//   - p1_ctl = keys | joystick_0[4:0]; p2_ctl = keys | joystick_1[4:0].
//   - start1 = keys | j0[5]; start2 = keys | j0[6] | j1[5].
//   - coin_req = keys | j0[7] | j1[7].
//  Coin FSM (cnt is 24 bits, down-counter):
//   - IDLE: coin_req=1 -> PULSE, cnt=COIN_PULSE-1, coin=1 next cycle.
//   - PULSE: coin=1; cnt==0 -> GAP, cnt=COIN_GAP-1; else cnt--.
//   - GAP: coin=0; cnt==0 -> (coin_req ? HOLD : IDLE); else cnt--.
//   - HOLD: coin_req=0 -> IDLE.
//   - coin is high for exactly COIN_PULSE cycles per request; holding gives one coin.
//   - Requests during PULSE or GAP are dropped.
//   - Reset mid-pulse: coin=0 on the next edge; a coin still held after reset produces one new pulse.
// CONFIGURATION
//  INPUT_AUTOFIRE_EN defined:
//   - A free-running phase toggles every AUTOFIRE_DIV cycles.
//   - On the rising edge of a held fire, that player's phase is forced to 1, so the first shot is immediate.
//   - With autofire=1, each fire output = held & phase.
//   - With autofire=0, fire outputs are unchanged.
//  INPUT_AUTOFIRE_EN undefined: autofire port is unused; no divider logic is built.
// TESTING
//  1 Hold reset_n=0 with ps2_key[10]=1, release -> all outputs 0, no event decoded.
//  2 Toggle with {pressed=1,ext=1,75} -> p1_ctl[3]=1 one cycle later.
//    Release event clears it. Repeat with ext=0 -> same result.
//  3 Press 29, press 14, release 14 -> p1_ctl[4] stays 1. Release 29 -> 0.
//  4 COIN_PULSE=4, COIN_GAP=8; hold '5' for 50 cycles -> exactly one 4-cycle coin pulse.
//    Release, re-press -> second pulse. Press during GAP -> no pulse.
//  5 Assert reset_n=0 at PULSE cycle 2 with coin held -> coin=0 next edge.
//    After reset -> one fresh 4-cycle pulse.
//  6 INPUT_AUTOFIRE_EN, AUTOFIRE_DIV=3, autofire=1, hold j0[4] -> p1_ctl[4] is 1,1,1,0,0,0,...
//    autofire=0 -> steady 1.

Source files
------------

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 + joystick to player controls, coin shaper, optional autofire (INPUT_AUTOFIRE_EN)
module arcade_input_mapper #(
    parameter int COIN_PULSE   = 120000,
    parameter int COIN_GAP     = 1200000,
    parameter int AUTOFIRE_DIV = 300000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        autofire,
    output logic [4:0]  p1_ctl,
    output logic [4:0]  p2_ctl,
    output logic        start1,
    output logic        start2,
    output logic        coin
);

    localparam int K_UP = 0, K_DOWN = 1, K_LEFT = 2, K_RIGHT = 3, K_SPACE = 4, K_CTRL = 5;
    localparam int K_F1 = 6, K_ONE = 7, K_F2 = 8, K_TWO = 9, K_FIVE = 10, K_SIX = 11;
    localparam int K_R = 12, K_F = 13, K_D = 14, K_G = 15, K_A = 16, NKEYS = 17;

    localparam logic [23:0] PULSE_M1 = 24'(COIN_PULSE - 1);
    localparam logic [23:0] GAP_M1   = 24'(COIN_GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_HOLD} coin_state_t;

    logic              old_tgl_q;
    logic [NKEYS-1:0]  key_q, key_d;
    logic [4:0]        p1_q, p1_d, p2_q, p2_d;
    logic              start1_q, start1_d, start2_q, start2_d, coin_q, coin_d;
    coin_state_t       state_q, state_d;
    logic [23:0]       cnt_q, cnt_d;
    logic [4:0]        p1_raw, p2_raw;
    logic              coin_req, fire1, fire2;
    logic              unused_bits;

    // Key latches: on a toggle event the addressed key takes the pressed flag
    always_comb begin
        key_d = key_q;
        if (ps2_key[10] != old_tgl_q) begin
            case (ps2_key[7:0])
                8'h75: key_d[K_UP]    = ps2_key[9];
                8'h72: key_d[K_DOWN]  = ps2_key[9];
                8'h6B: key_d[K_LEFT]  = ps2_key[9];
                8'h74: key_d[K_RIGHT] = ps2_key[9];
                8'h14: key_d[K_CTRL]  = ps2_key[9];
                8'h29: if (!ps2_key[8]) key_d[K_SPACE] = ps2_key[9];
                8'h05: if (!ps2_key[8]) key_d[K_F1]    = ps2_key[9];
                8'h16: if (!ps2_key[8]) key_d[K_ONE]   = ps2_key[9];
                8'h06: if (!ps2_key[8]) key_d[K_F2]    = ps2_key[9];
                8'h1E: if (!ps2_key[8]) key_d[K_TWO]   = ps2_key[9];
                8'h2E: if (!ps2_key[8]) key_d[K_FIVE]  = ps2_key[9];
                8'h36: if (!ps2_key[8]) key_d[K_SIX]   = ps2_key[9];
                8'h2D: if (!ps2_key[8]) key_d[K_R]     = ps2_key[9];
                8'h2B: if (!ps2_key[8]) key_d[K_F]     = ps2_key[9];
                8'h23: if (!ps2_key[8]) key_d[K_D]     = ps2_key[9];
                8'h34: if (!ps2_key[8]) key_d[K_G]     = ps2_key[9];
                8'h1C: if (!ps2_key[8]) key_d[K_A]     = ps2_key[9];
                default: ;
            endcase
        end
    end

    // Merge keys with joystick words; uses next-state latches so outputs lag inputs by one cycle
    always_comb begin
        p1_raw   = {key_d[K_SPACE] | key_d[K_CTRL], key_d[K_UP], key_d[K_DOWN],
                    key_d[K_LEFT], key_d[K_RIGHT]} | joystick_0[4:0];
        p2_raw   = {key_d[K_A], key_d[K_R], key_d[K_F], key_d[K_D], key_d[K_G]} | joystick_1[4:0];
        start1_d = key_d[K_F1] | key_d[K_ONE] | joystick_0[5];
        start2_d = key_d[K_F2] | key_d[K_TWO] | joystick_0[6] | joystick_1[5];
        coin_req = key_d[K_FIVE] | key_d[K_SIX] | joystick_0[7] | joystick_1[7];
    end

`ifdef INPUT_AUTOFIRE_EN
    localparam logic [31:0] AF_M1 = 32'(AUTOFIRE_DIV - 1);
    logic [1:0]  held, prev_q, ph_q, ph_d;
    logic [31:0] div_q [2];
    logic [31:0] div_d [2];

    // Per-player fire phase; a fresh press restarts the phase high so the first shot is immediate
    always_comb begin
        held = {p2_raw[4], p1_raw[4]};
        for (int p = 0; p < 2; p++) begin
            ph_d[p]  = ph_q[p];
            div_d[p] = div_q[p];
            if (held[p] && !prev_q[p]) begin
                ph_d[p]  = 1'b1;
                div_d[p] = '0;
            end else if (div_q[p] == AF_M1) begin
                ph_d[p]  = ~ph_q[p];
                div_d[p] = '0;
            end else begin
                div_d[p] = div_q[p] + 32'd1;
            end
        end
        fire1 = autofire ? (held[0] & ph_d[0]) : held[0];
        fire2 = autofire ? (held[1] & ph_d[1]) : held[1];
    end

    // Autofire divider and phase registers
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            prev_q <= '0;
            ph_q   <= '0;
            div_q  <= '{default: '0};
        end else begin
            prev_q <= held;
            ph_q   <= ph_d;
            div_q  <= div_d;
        end
    end

    assign unused_bits = ^{joystick_0[15:8], joystick_1[15:8], joystick_1[6]};
`else
    assign fire1       = p1_raw[4];
    assign fire2       = p2_raw[4];
    assign unused_bits = ^{joystick_0[15:8], joystick_1[15:8], joystick_1[6], autofire};
`endif

    assign p1_d = {fire1, p1_raw[3:0]};
    assign p2_d = {fire2, p2_raw[3:0]};

    // Coin shaper: one fixed pulse per request, then a mandatory gap, then wait for release
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (coin_req) begin
                state_d = S_PULSE;
                cnt_d   = PULSE_M1;
            end
            S_PULSE: if (cnt_q == '0) begin
                state_d = S_GAP;
                cnt_d   = GAP_M1;
            end else begin
                cnt_d = cnt_q - 24'd1;
            end
            S_GAP: if (cnt_q == '0) begin
                state_d = coin_req ? S_HOLD : S_IDLE;
            end else begin
                cnt_d = cnt_q - 24'd1;
            end
            S_HOLD: if (!coin_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        coin_d = (state_d == S_PULSE);
    end

    // State, latch and output registers; toggle tracker follows ps2_key even in reset
    always_ff @(posedge clk_sys) begin
        old_tgl_q <= ps2_key[10];
        if (!reset_n) begin
            key_q    <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            start1_q <= 1'b0;
            start2_q <= 1'b0;
            coin_q   <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
        end else begin
            key_q    <= key_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            start1_q <= start1_d;
            start2_q <= start2_d;
            coin_q   <= coin_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign p1_ctl = p1_q;
    assign p2_ctl = p2_q;
    assign start1 = start1_q;
    assign start2 = start2_q;
    assign coin   = coin_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - scoreboard bench for arcade_input_mapper
module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic        autofire;
    logic [4:0]  p1_ctl, p2_ctl;
    logic        start1, start2, coin;

    int n_checks = 0;
    int n_pass   = 0;

    logic [12:0] exp_q [$];
    string       tag_q [$];

    arcade_input_mapper #(.COIN_PULSE(4), .COIN_GAP(8), .AUTOFIRE_DIV(3)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .autofire(autofire),
        .p1_ctl(p1_ctl), .p2_ctl(p2_ctl), .start1(start1), .start2(start2), .coin(coin)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [12:0] ev(input logic [4:0] p1, input logic [4:0] p2,
                                       input logic s1, input logic s2, input logic c);
        return {p1, p2, s1, s2, c};
    endfunction

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, want);
    endtask

    // Push expectation, clock once, pop and compare away from the edge
    task automatic step(input string tag, input logic [12:0] want);
        logic [12:0] got;
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(posedge clk_sys);
        #1;
        got = {p1_ctl, p2_ctl, start1, start2, coin};
        check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic press_release(input logic ext, input logic [7:0] code, input logic [12:0] want);
        key(1'b1, ext, code);
        step($sformatf("press_%0d_%h", ext, code), want);
        key(1'b0, ext, code);
        step($sformatf("release_%0d_%h", ext, code), 13'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};
        joystick_0 = '0;
        joystick_1 = '0;
        autofire   = 1'b0;

        // Reset with toggle bit high, then no spurious event
        for (int i = 0; i < 3; i++) step("reset", 13'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step("no_event", 13'd0);

        // Key table
        press_release(1'b1, 8'h75, ev(5'b01000, 5'b0, 0, 0, 0));
        press_release(1'b0, 8'h75, ev(5'b01000, 5'b0, 0, 0, 0));
        press_release(1'b1, 8'h72, ev(5'b00100, 5'b0, 0, 0, 0));
        press_release(1'b0, 8'h6B, ev(5'b00010, 5'b0, 0, 0, 0));
        press_release(1'b1, 8'h74, ev(5'b00001, 5'b0, 0, 0, 0));
        press_release(1'b0, 8'h29, ev(5'b10000, 5'b0, 0, 0, 0));
        press_release(1'b1, 8'h14, ev(5'b10000, 5'b0, 0, 0, 0));
        press_release(1'b1, 8'h29, 13'd0);
        press_release(1'b0, 8'h05, ev(5'b0, 5'b0, 1, 0, 0));
        press_release(1'b0, 8'h16, ev(5'b0, 5'b0, 1, 0, 0));
        press_release(1'b0, 8'h06, ev(5'b0, 5'b0, 0, 1, 0));
        press_release(1'b0, 8'h1E, ev(5'b0, 5'b0, 0, 1, 0));
        press_release(1'b0, 8'h2D, ev(5'b0, 5'b01000, 0, 0, 0));
        press_release(1'b0, 8'h2B, ev(5'b0, 5'b00100, 0, 0, 0));
        press_release(1'b0, 8'h23, ev(5'b0, 5'b00010, 0, 0, 0));
        press_release(1'b0, 8'h34, ev(5'b0, 5'b00001, 0, 0, 0));
        press_release(1'b0, 8'h1C, ev(5'b0, 5'b10000, 0, 0, 0));
        press_release(1'b0, 8'h15, 13'd0);

        // Shared-function keys are ORed
        key(1'b1, 1'b0, 8'h29); step("or_space", ev(5'b10000, 5'b0, 0, 0, 0));
        key(1'b1, 1'b0, 8'h14); step("or_ctrl", ev(5'b10000, 5'b0, 0, 0, 0));
        key(1'b0, 1'b0, 8'h14); step("or_ctrl_rel", ev(5'b10000, 5'b0, 0, 0, 0));
        key(1'b0, 1'b0, 8'h29); step("or_space_rel", 13'd0);

        // Joystick merge
        joystick_0 = 16'h001F; step("j0_dirs", ev(5'b11111, 5'b0, 0, 0, 0));
        joystick_0 = 16'h0060; step("j0_starts", ev(5'b0, 5'b0, 1, 1, 0));
        joystick_0 = 16'h0000;
        joystick_1 = 16'h003F; step("j1_all", ev(5'b0, 5'b11111, 0, 1, 0));
        joystick_1 = 16'hFF40; step("j1_unused", 13'd0);
        joystick_1 = 16'h0000; step("j_idle", 13'd0);

        // Coin shaping: held key, re-press, press during gap
        for (int i = 0; i < 80; i++) begin
            if (i == 0)  key(1'b1, 1'b0, 8'h2E);
            if (i == 50) key(1'b0, 1'b0, 8'h2E);
            if (i == 51) key(1'b1, 1'b0, 8'h36);
            if (i == 56) key(1'b0, 1'b0, 8'h36);
            if (i == 58) key(1'b1, 1'b0, 8'h2E);
            if (i == 60) key(1'b0, 1'b0, 8'h2E);
            step($sformatf("coin_%0d", i),
                 ev(5'b0, 5'b0, 0, 0, (i <= 3) || (i >= 51 && i <= 54)));
        end

        // Reset mid-pulse with joystick coin held
        for (int i = 0; i < 26; i++) begin
            joystick_0 = 16'h0080;
            reset_n    = (i != 1);
            step($sformatf("coinrst_%0d", i),
                 ev(5'b0, 5'b0, 0, 0, (i == 0) || (i >= 2 && i <= 5)));
        end
        joystick_0 = '0;
        for (int i = 0; i < 3; i++) step("coin_released", 13'd0);

        // Autofire
        autofire   = 1'b1;
        joystick_0 = 16'h0010;
`ifdef INPUT_AUTOFIRE_EN
        for (int i = 0; i < 12; i++)
            step($sformatf("af_%0d", i), ev({((i % 6) < 3), 4'b0}, 5'b0, 0, 0, 0));
        autofire = 1'b0;
        for (int i = 0; i < 4; i++) step("af_off", ev(5'b10000, 5'b0, 0, 0, 0));
`else
        for (int i = 0; i < 6; i++) step("af_absent", ev(5'b10000, 5'b0, 0, 0, 0));
`endif
        joystick_0 = '0;
        autofire   = 1'b0;
        step("final_idle", 13'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
